cmd_to_ascii: RTL and testbench

Serializes one plotter command, an opcode plus a binary magnitude, into the ASCII character stream that the display and command path consume. The stream is the opcode letter ('f' forward, 'r' right), then the decimal digits of the magnitude with the most significant digit first and leading zeros suppressed, then an optional line-feed terminator. The block sits between the command source and the character sink. Commands are accepted on a valid/ready handshake, and characters are emitted one per handshake.

---
 rtl/plotter_pkg.sv | 20 ++
 rtl/bin_to_bcd.sv | 53 +++++
 rtl/cmd_to_ascii.sv | 128 ++++++++++++
 tb/tb_cmd_to_ascii.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/plotter_pkg.sv
// Shared constants and FSM state type for the plotter command path.
package plotter_pkg;

  localparam logic [7:0] ASCII_F  = 8'd102;
  localparam logic [7:0] ASCII_R  = 8'd114;
  localparam logic [7:0] ASCII_0  = 8'd48;
  localparam logic [7:0] ASCII_LF = 8'd10;

  localparam logic OP_FWD   = 1'b0;
  localparam logic OP_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    SEND_OP,
    SEND_DIG,
    SEND_TERM
  } state_t;

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble: converts bin to packed BCD in exactly MAG_W cycles after start.
module bin_to_bcd #(
  parameter int MAG_W = 10,
  parameter int NDIG  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MAG_W-1:0]    bin,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int CNT_W = $clog2(MAG_W + 1);

  logic [MAG_W-1:0]  sh;
  logic [4*NDIG-1:0] acc;
  logic [4*NDIG-1:0] adj;
  logic [CNT_W-1:0]  cnt;
  logic              active;

  always_comb begin
    adj = acc;
    for (int i = 0; i < NDIG; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // bcd is the result of the step in progress, so on the done cycle it already
  // holds the final value and the consumer can latch it on the same edge.
  assign bcd  = {adj[4*NDIG-2:0], sh[MAG_W-1]};
  assign done = active && (cnt == CNT_W'(MAG_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sh     <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sh     <= bin;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      sh  <= sh << 1;
      acc <= bcd;
      cnt <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_to_ascii.sv
// Serializes an opcode + magnitude into 'f'/'r', decimal digits (MSD first, no leading zeros), optional LF.
// Handshakes: a transfer happens on a rising clk edge where valid && ready; once
// char_valid is raised it and char_out hold until char_ready is seen (or reset).
module cmd_to_ascii
  import plotter_pkg::*;
#(
  parameter int MAG_W   = 10,
  parameter int NDIG    = 4,
  parameter int TERM_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [MAG_W-1:0] cmd_mag,
  output logic             char_valid,
  input  logic             char_ready,
  output logic [7:0]       char_out,
  output logic             busy,
  output state_t           fsm_state
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t            state;
  logic              op_q;
  logic [4*NDIG-1:0] dig;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_m1;
  logic              start;
  logic              conv_done;
  logic [4*NDIG-1:0] conv_bcd;

  assign fsm_state = state;
  assign start     = (state == IDLE) && cmd_valid && cmd_ready;
  assign idx_m1    = idx - 1'b1;

  bin_to_bcd #(.MAG_W(MAG_W), .NDIG(NDIG)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (cmd_mag),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Index of the most significant nonzero digit; 0 for a zero magnitude.
  function automatic logic [IDX_W-1:0] top_digit(input logic [4*NDIG-1:0] v);
    top_digit = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] != 4'd0) top_digit = IDX_W'(i);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= OP_FWD;
      dig        <= '0;
      idx        <= '0;
      cmd_ready  <= 1'b1;
      char_valid <= 1'b0;
      char_out   <= 8'd0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= cmd_op;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_done) begin
            dig        <= conv_bcd;
            idx        <= top_digit(conv_bcd);
            char_valid <= 1'b1;
            char_out   <= (op_q == OP_RIGHT) ? ASCII_R : ASCII_F;
            state      <= SEND_OP;
          end
        end
        SEND_OP: begin
          if (char_ready) begin
            char_out <= ASCII_0 + {4'd0, dig[4*idx +: 4]};
            state    <= SEND_DIG;
          end
        end
        SEND_DIG: begin
          if (char_ready) begin
            if (idx != '0) begin
              idx      <= idx_m1;
              char_out <= ASCII_0 + {4'd0, dig[4*idx_m1 +: 4]};
            end else if (TERM_EN != 0) begin
              char_out <= ASCII_LF;
              state    <= SEND_TERM;
            end else begin
              char_valid <= 1'b0;
              char_out   <= 8'd0;
              cmd_ready  <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        SEND_TERM: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            char_out   <= 8'd0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          char_valid <= 1'b0;
          char_out   <= 8'd0;
          cmd_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_to_ascii.sv
// Scoreboard bench for cmd_to_ascii: a decimal-string model fills exp_q, a negedge monitor drains it.
module tb_cmd_to_ascii;
  import plotter_pkg::*;

  localparam int MAG_W   = 10;
  localparam int NDIG    = 4;
  localparam int TERM_EN = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [MAG_W-1:0] cmd_mag;
  logic             char_valid;
  logic             char_ready;
  logic [7:0]       char_out;
  logic             busy;
  state_t           fsm_state;

  cmd_to_ascii #(.MAG_W(MAG_W), .NDIG(NDIG), .TERM_EN(TERM_EN)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_mag    (cmd_mag),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_out   (char_out),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         acc_q[$];
  int         last_end = -100;
  logic       rand_ready = 1'b0;
  logic       prev_valid = 1'b0;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_char = 8'd0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: the decimal text of the magnitude, built by repeated division.
  task automatic model(input logic op, input int mag);
    int         m;
    logic [7:0] d[$];
    exp_q.push_back(op ? 8'd114 : 8'd102);
    m = mag;
    do begin
      d.push_front(8'(48 + m % 10));
      m = m / 10;
    end while (m > 0);
    foreach (d[i]) exp_q.push_back(d[i]);
    if (TERM_EN != 0) exp_q.push_back(8'd10);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic op, input int mag, input bit push_model, output int acc);
    int n = 0;
    acc       = -1;
    cmd_op    = op;
    cmd_mag   = MAG_W'(mag);
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 500);
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    if (push_model) model(op, mag);
    acc = cyc;
    acc_q.push_back(cyc);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 3000) check("drain_timeout", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 char_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("ready_vs_busy", int'(cmd_ready), int'(!busy));
      if (hold_pending) begin
        check("hold_valid", int'(char_valid), 1);
        check("hold_char", int'(char_out), int'(hold_char));
      end
      if (char_valid && !prev_valid) begin
        if (acc_q.size() == 0) check("first_char_without_cmd", 1, 0);
        else check("first_char_latency", cyc - acc_q.pop_front(), MAG_W + 1);
      end
      if (char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_char", int'(char_out), -1);
        end else begin
          check("char", int'(char_out), int'(exp_q.pop_front()));
        end
        if (char_out == 8'd10) last_end = cyc;
      end
      hold_pending = char_valid && !char_ready;
      hold_char    = char_out;
    end else begin
      hold_pending = 1'b0;
    end
    prev_valid = char_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2, n, mag;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 1'b0;
    cmd_mag    = '0;
    char_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_char_valid", int'(char_valid), 0);
    check("rst_char_out", int'(char_out), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // 'f123\n' with first char 11 cycles after acceptance
    send_cmd(1'b0, 123, 1'b1, a1);
    drain();

    // zero magnitude: single '0'
    send_cmd(1'b1, 0, 1'b1, a1);
    drain();

    // back-to-back, interior zeros; second cmd held valid while busy
    send_cmd(1'b0, 1023, 1'b1, a1);
    send_cmd(1'b1, 1003, 1'b1, a2);
    check("b2b_accept_cycle", a2, last_end + 1);
    drain();

    // backpressure on '4' of 45
    char_ready = 1'b0;
    send_cmd(1'b1, 45, 1'b1, a1);
    n = 0;
    while (!char_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("stall_op_char", int'(char_out), 114);
    char_ready = 1'b1;
    @(posedge clk);
    #1 char_ready = 1'b0;
    check("stall_digit4", int'(char_out), 52);
    repeat (5) @(posedge clk);
    #1;
    check("stall_hold_char", int'(char_out), 52);
    check("stall_hold_valid", int'(char_valid), 1);
    char_ready = 1'b1;
    drain();

    // reset mid-stream after the '1' of 123 has been handed over
    send_cmd(1'b0, 123, 1'b0, a1);
    exp_q.push_back(8'd102);
    exp_q.push_back(8'd49);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_char_valid", int'(char_valid), 0);
    check("midrst_cmd_ready", int'(cmd_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_char_out", int'(char_out), 0);
    reset = 1'b0;
    acc_q.delete();
    repeat (30) @(posedge clk);
    #1;

    // randomized commands under random sink backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      mag = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 1023));
      send_cmd(1'($urandom_range(0, 1)), mag, 1'b1, a1);
    end
    send_cmd(1'b0, 1023, 1'b1, a1);
    send_cmd(1'b1, 10, 1'b1, a1);
    drain();
    rand_ready = 1'b0;
    #2 char_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
